// File: rtl/mem_pkg.sv
// Shared types and constants for the multicycle memory port.
// funct3 access-size encodings and the bus FSM state type.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_interface_load_align.sv
// Load data alignment: moves the addressed lane down to bit 0
// and sign- or zero-extends it according to funct3.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] sh;

  // lane shift followed by size/sign extension
  always_comb begin
    sh   = rdata >> {a_lo, 3'b000};
    data = rdata;
    unique case (funct3)
      F3_B:    data = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   data = {24'h0, sh[7:0]};
      F3_H:    data = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   data = {16'h0, sh[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_interface.sv
// Multicycle instruction/data memory port with registered outputs.
// Optional MEM_INTERFACE_MISALIGN_CHECK_EN rejects misaligned commands.
module mem_interface
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic              adr_src,
  input  logic              mem_write,
  input  logic              ir_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [31:0]       write_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] old_pc,
  output logic [31:0]       data,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  mem_state_t        state, state_d;
  logic [CW-1:0]     cnt;
  logic [1:0]        a_lo;
  logic [2:0]        f3_q;
  logic              we_q, irw_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_sel;
  logic [7:0]        be_wide;
  logic [31:0]       wdata_d;
  logic [31:0]       ld_data;
  logic              mis, start, fin, tmo, ld, bad;

  assign addr_sel = adr_src ? alu_out : pc;

  // byte enables and lane-aligned store data for the incoming command
  always_comb begin
    be_wide = 8'h0F;
    wdata_d = write_data;
    unique case (1'b1)
      mem_write && funct3[1:0] == 2'b00: begin
        be_wide = 8'h01 << addr_sel[1:0];
        wdata_d = {4{write_data[7:0]}};
      end
      mem_write && funct3[1:0] == 2'b01: begin
        be_wide = 8'h03 << addr_sel[1:0];
        wdata_d = write_data << {addr_sel[1:0], 3'b000};
      end
      default: begin
        be_wide = 8'h0F;
        wdata_d = write_data;
      end
    endcase
  end

`ifdef MEM_INTERFACE_MISALIGN_CHECK_EN
  // address must be naturally aligned to the access size
  always_comb begin
    mis = 1'b0;
    if (!mem_write && ir_write)
      mis = |addr_sel[1:0];
    else if (funct3[1:0] == 2'b01)
      mis = addr_sel[0];
    else if (funct3[1:0] == 2'b10)
      mis = |addr_sel[1:0];
  end
`else
  assign mis = 1'b0;
`endif

  load_align u_load_align (
    .rdata  (mem_rdata),
    .a_lo   (a_lo),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  // next-state and transaction strobes
  always_comb begin
    state_d = state;
    start   = 1'b0;
    fin     = 1'b0;
    tmo     = 1'b0;
    ld      = 1'b0;
    bad     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (mis) begin
            bad = 1'b1;
          end else begin
            start   = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          if (we_q) begin
            fin     = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end else if (cnt == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          ld      = 1'b1;
          fin     = 1'b1;
          state_d = S_IDLE;
        end else if (cnt == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, timeout counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'h0;
      mem_wdata <= '0;
      instr     <= '0;
      old_pc    <= '0;
      data      <= '0;
      a_lo      <= 2'b00;
      f3_q      <= 3'b000;
      we_q      <= 1'b0;
      irw_q     <= 1'b0;
      pc_q      <= '0;
    end else begin
      state   <= state_d;
      cnt     <= (state_d != state || state == S_IDLE) ? '0 : cnt + 1'b1;
      busy    <= state_d != S_IDLE;
      mem_req <= state_d == S_REQ;
      done    <= fin | tmo | bad;
      if (tmo | bad)
        err <= 1'b1;
      if (start) begin
        mem_addr  <= {addr_sel[ADDR_W-1:2], 2'b00};
        mem_be    <= be_wide[3:0];
        mem_wdata <= wdata_d;
        mem_we    <= mem_write;
        a_lo      <= addr_sel[1:0];
        f3_q      <= funct3;
        we_q      <= mem_write;
        irw_q     <= ir_write;
        pc_q      <= pc;
      end else if (state_d != S_REQ) begin
        mem_we <= 1'b0;
      end
      if (ld) begin
        if (irw_q) begin
          instr  <= mem_rdata;
          old_pc <= pc_q;
        end else begin
          data <= ld_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: directed cases plus
// random transactions with random bus wait states.
module tb_mem_interface;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        adr_src = 1'b0;
  logic        mem_write = 1'b0;
  logic        ir_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] pc = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] write_data = '0;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] instr, old_pc, data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_instr = '0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;

  mem_interface #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid),
    .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .funct3(funct3), .pc(pc), .alu_out(alu_out),
    .write_data(write_data), .busy(busy), .done(done),
    .instr(instr), .old_pc(old_pc), .data(data), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_err", 32'(err), 0);
    check("rst_be", 32'(mem_be), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_instr", instr, 0);
    check("rst_oldpc", old_pc, 0);
    check("rst_data", data, 0);
  endtask

  function automatic logic [31:0] ext_load(input logic [31:0] rd,
                                           input logic [1:0] lo,
                                           input logic [2:0] f3);
    int unsigned v;
    v = rd >> (8 * lo);
    case (f3)
      3'd0: begin v = v % 256; if (v >= 128) v = v + 32'hFFFFFF00; end
      3'd4: v = v % 256;
      3'd1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
      3'd5: v = v % 65536;
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic run_txn(input logic we, input logic irw, input logic src,
                         input logic [2:0] f3, input logic [31:0] pcv,
                         input logic [31:0] av, input logic [31:0] wd,
                         input logic [31:0] rd, input int gw, input int rw);
    logic [31:0] ea, mask, ewd;
    logic [3:0]  be;
    int          sz, base, k;
    ea = src ? av : pcv;
    sz = 4;
    if (we) sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    base = (sz == 4) ? 0 : int'(ea[1:0]);
    be = '0; mask = '0; ewd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= base && i < base + sz) begin
        k = i - base;
        be[i] = 1'b1;
        mask[8*i +: 8] = 8'hFF;
        ewd[8*i +: 8] = wd[8*k +: 8];
      end
    end
    cmd_valid = 1'b1; adr_src = src; mem_write = we; ir_write = irw;
    funct3 = f3; pc = pcv; alu_out = av; write_data = wd;
    step();
    cmd_valid = 1'b0;
    pc = $urandom; alu_out = $urandom; write_data = $urandom;
    funct3 = 3'($urandom); mem_write = 1'($urandom);
    check("req_on", 32'(mem_req), 1);
    check("busy_req", 32'(busy), 1);
    check("addr", mem_addr, ea & 32'hFFFF_FFFC);
    check("we", 32'(mem_we), 32'(we));
    check("be", 32'(mem_be), we ? 32'(be) : 32'hF);
    if (we) check("wdata", mem_wdata & mask, ewd);
    if (we && sz == 1) check("sb_repl", mem_wdata, {4{wd[7:0]}});
    for (int i = 0; i < gw; i++) begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'($urandom);
      mem_rdata = $urandom;
      step();
      check("stall_req", 32'(mem_req), 1);
      check("stall_addr", mem_addr, ea & 32'hFFFF_FFFC);
      check("stall_busy_done", {busy, done}, 2'b10);
    end
    mem_gnt = 1'b1; mem_rvalid = 1'b0;
    step();
    mem_gnt = 1'b0;
    if (!we) begin
      check("resp_req", 32'(mem_req), 0);
      check("resp_busy_done", {busy, done}, 2'b10);
      for (int i = 0; i < rw; i++) begin
        mem_rdata = $urandom;
        step();
        check("wait_busy_done", {busy, done}, 2'b10);
      end
      mem_rvalid = 1'b1; mem_rdata = rd;
      step();
      mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (irw) begin
        m_instr = rd;
        m_pc = pcv;
      end else begin
        m_data = ext_load(rd, ea[1:0], f3);
      end
    end
    check("done", 32'(done), 1);
    check("busy_end", 32'(busy), 0);
    check("req_end", 32'(mem_req), 0);
    check("instr", instr, m_instr);
    check("old_pc", old_pc, m_pc);
    check("data", data, m_data);
    check("err", 32'(err), 32'(m_err));
    step();
    check("done_once", 32'(done), 0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind, lat;
    logic [2:0]  ld_f3 [5];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    step();
    step();
    chk_reset();
    rst_n = 1'b1;
    step();

    run_txn(0, 1, 0, 3'd2, 32'h100, 32'h0, 32'h0, 32'h00500093, 0, 0);
    run_txn(0, 0, 1, 3'd0, 32'h104, 32'h203, 32'h0, 32'h80FFFFFF, 0, 0);
    check("lb_val", data, 32'hFFFFFF80);
    run_txn(0, 0, 1, 3'd4, 32'h104, 32'h203, 32'h0, 32'h80FFFFFF, 0, 0);
    check("lbu_val", data, 32'h00000080);
    run_txn(1, 0, 1, 3'd1, 32'h108, 32'h202, 32'h1234, 32'h0, 0, 0);
    run_txn(1, 0, 1, 3'd1, 32'h10C, 32'h202, 32'h1234, 32'h0, 5, 0);
    run_txn(0, 0, 1, 3'd2, 32'h110, 32'h300, 32'h0, 32'hCAFEF00D, 5, 3);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      a = $urandom & 32'hFFFF_FFFC;
      if (kind == 0) begin
        run_txn(0, 1, 0, 3'($urandom), a, $urandom, $urandom, $urandom,
                $urandom_range(0, 5), $urandom_range(0, 6));
      end else begin
        if (kind == 1) f3 = ld_f3[$urandom_range(0, 4)];
        else f3 = 3'($urandom_range(0, 2));
        if (f3[1:0] == 2'b00) a = a + 32'($urandom_range(0, 3));
        else if (f3[1:0] == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
        run_txn(kind == 2, 0, 1, f3, $urandom & 32'hFFFF_FFFC, a,
                $urandom, $urandom, $urandom_range(0, 5),
                $urandom_range(0, 6));
      end
    end

    cmd_valid = 1'b1; adr_src = 1'b0; mem_write = 1'b0; ir_write = 1'b1;
    pc = 32'h500;
    step();
    cmd_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    lat = 0;
    while (lat < 3 * TMO) begin
      step();
      lat++;
      if (done) break;
    end
    m_err = 1'b1;
    check("tmo_lat", lat, TMO);
    check("tmo_err", 32'(err), 1);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_instr", instr, m_instr);
    step();
    check("tmo_done_once", 32'(done), 0);

    cmd_valid = 1'b1; adr_src = 1'b1; mem_write = 1'b0; ir_write = 1'b0;
    funct3 = 3'd2; alu_out = 32'h600;
    step();
    cmd_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset();
    m_instr = '0; m_pc = '0; m_data = '0; m_err = 1'b0;
    mem_rvalid = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_idle", {busy, done}, 2'b00);
    end
    mem_rvalid = 1'b0;

    cmd_valid = 1'b1; adr_src = 1'b1; mem_write = 1'b1; funct3 = 3'd2;
    alu_out = 32'h700;
    step();
    cmd_valid = 1'b0;
    check("req_pre_rst", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("req_async_drop", 32'(mem_req), 0);
    step();
    rst_n = 1'b1;
    step();
    check("req_rst_done", 32'(done), 0);

`ifdef MEM_INTERFACE_MISALIGN_CHECK_EN
    cmd_valid = 1'b1; adr_src = 1'b1; mem_write = 1'b0; ir_write = 1'b0;
    funct3 = 3'd2; alu_out = 32'h201;
    step();
    cmd_valid = 1'b0;
    check("mis_req", 32'(mem_req), 0);
    check("mis_busy", 32'(busy), 0);
    check("mis_done", 32'(done), 1);
    check("mis_err", 32'(err), 1);
    step();
    check("mis_req2", 32'(mem_req), 0);
    check("mis_done2", 32'(done), 0);
`else
    run_txn(1, 0, 1, 3'd1, 32'h0, 32'h203, 32'hABCD, 32'h0, 1, 0);
    check("sh3_be", 32'(mem_be), 32'h8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
